// File: rtl/pkt_wr_sched.sv
// Write-command scheduler: buffers packet pulses from two packetizers, arbitrates
// round-robin onto the DDR command port and interleaves periodic refresh commands.
module pkt_wr_sched #(
  parameter int ADDR_W       = 24,
  parameter int REGION_WORDS = 1024,
  parameter int REF_PERIOD   = 780
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              pkt0_valid,
  input  logic [255:0]      pkt0_data,
  input  logic              pkt1_valid,
  input  logic [255:0]      pkt1_data,
  input  logic [ADDR_W-1:0] base0,
  input  logic [ADDR_W-1:0] base1,
  input  logic              clr_ovf,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [255:0]      cmd_data,
  output logic              ovf0,
  output logic              ovf1,
  output logic              busy
);

  localparam int PTR_W = $clog2(REGION_WORDS);
  localparam int CNT_W = $clog2(REF_PERIOD);

  typedef enum logic [1:0] {IDLE, WR, REF} state_t;

  state_t              state_q, state_d;
  logic [1:0]          full_q, full_d;
  logic [255:0]        slot_data_q [2];
  logic [255:0]        slot_data_d [2];
  logic [PTR_W-1:0]    ptr_q [2];
  logic [PTR_W-1:0]    ptr_d [2];
  logic [CNT_W-1:0]    ref_cnt_q, ref_cnt_d;
  logic                ref_pending_q, ref_pending_d;
  logic                last_grant_q, last_grant_d;
  logic [1:0]          ovf_q, ovf_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [255:0]        cmd_data_q, cmd_data_d;
  logic                busy_q, busy_d;

  logic [1:0]          in_valid;
  logic [255:0]        in_data [2];
  logic [ADDR_W-1:0]   base [2];
  logic                sel;
  logic [1:0]          grant;
  logic                accept;
  logic                ref_term;

  assign in_valid   = {pkt1_valid, pkt0_valid};
  assign in_data[0] = pkt0_data;
  assign in_data[1] = pkt1_data;
  assign base[0]    = base0;
  assign base[1]    = base1;

  // Lone full slot wins; on a tie the requester that was not granted last wins.
  assign sel      = full_q[1] & (~full_q[0] | ~last_grant_q);
  assign accept   = cmd_valid_q & cmd_ready;
  assign ref_term = (ref_cnt_q == CNT_W'(REF_PERIOD - 1));

  always_comb begin
    state_d       = state_q;
    full_d        = full_q;
    slot_data_d   = slot_data_q;
    ptr_d         = ptr_q;
    ref_pending_d = ref_pending_q;
    last_grant_d  = last_grant_q;
    ovf_d         = ovf_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_wr_d      = cmd_wr_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_data_d    = cmd_data_q;
    grant         = 2'b00;
    ref_cnt_d     = ref_term ? '0 : ref_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (ref_pending_q) begin
          state_d     = REF;
          cmd_valid_d = 1'b1;
          cmd_wr_d    = 1'b0;
          cmd_addr_d  = '0;
          cmd_data_d  = '0;
        end else if (|full_q) begin
          state_d      = WR;
          grant[sel]   = 1'b1;
          cmd_valid_d  = 1'b1;
          cmd_wr_d     = 1'b1;
          cmd_data_d   = slot_data_q[sel];
          cmd_addr_d   = base[sel] + ADDR_W'({ptr_q[sel], 5'b00000});
          ptr_d[sel]   = ptr_q[sel] + PTR_W'(1);
          last_grant_d = sel;
        end
      end
      WR: begin
        if (accept) begin
          state_d     = IDLE;
          cmd_valid_d = 1'b0;
        end
      end
      REF: begin
        if (accept) begin
          state_d       = IDLE;
          cmd_valid_d   = 1'b0;
          ref_pending_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase

    // A fresh expiry is never lost, even on the edge that retires a refresh.
    if (ref_term) ref_pending_d = 1'b1;

    if (clr_ovf) ovf_d = 2'b00;

    for (int i = 0; i < 2; i++) begin
      if (grant[i]) full_d[i] = 1'b0;
      if (in_valid[i]) begin
        if (!full_q[i] || grant[i]) begin
          slot_data_d[i] = in_data[i];
          full_d[i]      = 1'b1;
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
    end

    busy_d = (state_d != IDLE) || (|full_d) || ref_pending_d;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q       <= IDLE;
      full_q        <= 2'b00;
      slot_data_q   <= '{default: '0};
      ptr_q         <= '{default: '0};
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      last_grant_q  <= 1'b1;
      ovf_q         <= 2'b00;
      cmd_valid_q   <= 1'b0;
      cmd_wr_q      <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_data_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      slot_data_q   <= slot_data_d;
      ptr_q         <= ptr_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      last_grant_q  <= last_grant_d;
      ovf_q         <= ovf_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_wr_q      <= cmd_wr_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_data_q    <= cmd_data_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_wr    = cmd_wr_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_data  = cmd_data_q;
  assign ovf0      = ovf_q[0];
  assign ovf1      = ovf_q[1];
  assign busy      = busy_q;

endmodule

// File: tb/tb_pkt_wr_sched.sv
// Directed bench for pkt_wr_sched: one small-region instance for write traffic,
// one short-refresh-period instance for refresh timing and priority.
module tb_pkt_wr_sched;

  logic          rclk;
  logic          rrst_n, rrst_n_b;
  logic          pkt0_valid, pkt1_valid, pkt0_valid_b;
  logic [255:0]  pkt0_data, pkt1_data, pkt0_data_b;
  logic [23:0]   base0, base1, base0_b, base1_b;
  logic          clr_ovf, cmd_ready, cmd_ready_b, zero_b;
  logic [255:0]  zero_data_b;
  logic          cmd_valid, cmd_wr, ovf0, ovf1, busy;
  logic [23:0]   cmd_addr;
  logic [255:0]  cmd_data;
  logic          cmd_valid_b, cmd_wr_b, ovf0_b, ovf1_b, busy_b;
  logic [23:0]   cmd_addr_b;
  logic [255:0]  cmd_data_b;

  int checks = 0;
  int errors = 0;

  pkt_wr_sched #(.ADDR_W(24), .REGION_WORDS(4), .REF_PERIOD(4096)) u_dut (
    .rclk(rclk), .rrst_n(rrst_n),
    .pkt0_valid(pkt0_valid), .pkt0_data(pkt0_data),
    .pkt1_valid(pkt1_valid), .pkt1_data(pkt1_data),
    .base0(base0), .base1(base1), .clr_ovf(clr_ovf),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .ovf0(ovf0), .ovf1(ovf1), .busy(busy)
  );

  pkt_wr_sched #(.ADDR_W(24), .REGION_WORDS(4), .REF_PERIOD(16)) u_ref (
    .rclk(rclk), .rrst_n(rrst_n_b),
    .pkt0_valid(pkt0_valid_b), .pkt0_data(pkt0_data_b),
    .pkt1_valid(zero_b), .pkt1_data(zero_data_b),
    .base0(base0_b), .base1(base1_b), .clr_ovf(zero_b),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_wr(cmd_wr_b),
    .cmd_addr(cmd_addr_b), .cmd_data(cmd_data_b),
    .ovf0(ovf0_b), .ovf1(ovf1_b), .busy(busy_b)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic tick;
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [31:0] n);
    return {8{n ^ 32'hC0DE_0000}};
  endfunction

  // Expects a write command to be presented in the current cycle.
  task automatic chk_wr(input string tag, input logic [23:0] addr, input logic [255:0] data);
    chk({tag, ".valid"}, 256'(cmd_valid), 256'(1));
    chk({tag, ".wr"},    256'(cmd_wr),    256'(1));
    chk({tag, ".addr"},  256'(cmd_addr),  256'(addr));
    chk({tag, ".data"},  cmd_data,        data);
    $display("txn %s: wr=%0b addr=%06h data[31:0]=%08h", tag, cmd_wr, cmd_addr, cmd_data[31:0]);
  endtask

  task automatic pulse(input logic v0, input logic v1, input logic [255:0] d0, input logic [255:0] d1);
    pkt0_valid = v0; pkt0_data = d0;
    pkt1_valid = v1; pkt1_data = d1;
    tick();
    pkt0_valid = 1'b0; pkt1_valid = 1'b0;
  endtask

  task automatic do_reset;
    rrst_n = 1'b0;
    tick();
    tick();
    rrst_n = 1'b1;
  endtask

  initial begin
    rrst_n = 1'b0; rrst_n_b = 1'b0;
    pkt0_valid = 1'b0; pkt1_valid = 1'b0; pkt0_valid_b = 1'b0;
    pkt0_data = '0; pkt1_data = '0; pkt0_data_b = '0;
    base0 = 24'h000100; base1 = 24'h800000;
    base0_b = 24'h001000; base1_b = 24'h002000;
    clr_ovf = 1'b0; cmd_ready = 1'b1; cmd_ready_b = 1'b1;
    zero_b = 1'b0; zero_data_b = '0;
    tick();
    tick();

    // Reset values
    chk("rst.valid", 256'(cmd_valid), 256'(0));
    chk("rst.wr",    256'(cmd_wr),    256'(0));
    chk("rst.addr",  256'(cmd_addr),  256'(0));
    chk("rst.data",  cmd_data,        256'(0));
    chk("rst.ovf0",  256'(ovf0),      256'(0));
    chk("rst.ovf1",  256'(ovf1),      256'(0));
    chk("rst.busy",  256'(busy),      256'(0));
    rrst_n = 1'b1;
    tick();

    // Single packet: cmd_valid two cycles after the strobe
    pulse(1'b1, 1'b0, pat(32'hA), '0);
    chk("single.c1_valid", 256'(cmd_valid), 256'(0));
    chk("single.c1_busy",  256'(busy),      256'(1));
    tick();
    chk_wr("single.pkt1", 24'h000100, pat(32'hA));
    tick();
    chk("single.after_accept", 256'(cmd_valid), 256'(0));
    pulse(1'b1, 1'b0, pat(32'hB), '0);
    tick();
    chk_wr("single.pkt2", 24'h000120, pat(32'hB));
    tick();

    // Simultaneous strobes, twice: req0 first each time
    base0 = 24'h000000;
    do_reset();
    pulse(1'b1, 1'b1, pat(32'hC), pat(32'hD));
    tick();
    chk_wr("simul.r0a", 24'h000000, pat(32'hC));
    tick();
    chk("simul.gap", 256'(cmd_valid), 256'(0));
    tick();
    chk_wr("simul.r1a", 24'h800000, pat(32'hD));
    tick();
    pulse(1'b1, 1'b1, pat(32'hE), pat(32'hF));
    tick();
    chk_wr("simul.r0b", 24'h000020, pat(32'hE));
    tick();
    tick();
    chk_wr("simul.r1b", 24'h800020, pat(32'hF));
    chk("simul.ovf0", 256'(ovf0), 256'(0));
    chk("simul.ovf1", 256'(ovf1), 256'(0));
    tick();

    // Backpressure: third packet dropped, first held stable
    do_reset();
    cmd_ready = 1'b0;
    pulse(1'b1, 1'b0, pat(32'h11), '0);
    tick();
    pulse(1'b1, 1'b0, pat(32'h12), '0);
    chk_wr("bp.hold1", 24'h000000, pat(32'h11));
    chk("bp.ovf_before", 256'(ovf0), 256'(0));
    tick();
    pulse(1'b1, 1'b0, pat(32'h13), '0);
    chk("bp.ovf_after", 256'(ovf0), 256'(1));
    repeat (7) tick();
    chk_wr("bp.hold2", 24'h000000, pat(32'h11));
    cmd_ready = 1'b1;
    tick();
    chk("bp.drop_valid", 256'(cmd_valid), 256'(0));
    tick();
    chk_wr("bp.pkt2", 24'h000020, pat(32'h12));
    tick();
    tick();
    tick();
    chk("bp.no_third", 256'(cmd_valid), 256'(0));
    chk("bp.idle_busy", 256'(busy),     256'(0));
    chk("bp.ovf_sticky", 256'(ovf0),    256'(1));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("bp.clr_ovf", 256'(ovf0), 256'(0));

    // Pointer wrap with a 4-slot region
    base0 = 24'h000040;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      logic [23:0] exp_addr;
      exp_addr = 24'h000040 + 24'((i % 4) * 32);
      pulse(1'b1, 1'b0, pat(32'h20 + 32'(i)), '0);
      tick();
      chk_wr($sformatf("wrap.%0d", i), exp_addr, pat(32'h20 + 32'(i)));
      tick();
    end

    // Asynchronous reset while a command is stalled
    cmd_ready = 1'b0;
    pulse(1'b1, 1'b0, pat(32'h30), '0);
    tick();
    pulse(1'b1, 1'b0, pat(32'h31), '0);
    pulse(1'b1, 1'b0, pat(32'h32), '0);
    chk("mid.valid_before", 256'(cmd_valid), 256'(1));
    chk("mid.ovf_before",   256'(ovf0),      256'(1));
    rrst_n = 1'b0;
    #1;
    chk("mid.valid_async", 256'(cmd_valid), 256'(0));
    chk("mid.ovf_async",   256'(ovf0),      256'(0));
    chk("mid.busy_async",  256'(busy),      256'(0));
    #3;
    rrst_n = 1'b1;
    tick();
    cmd_ready = 1'b1;
    tick();
    chk("mid.no_stale", 256'(busy), 256'(0));
    pulse(1'b1, 1'b0, pat(32'h33), '0);
    tick();
    chk_wr("mid.restart", 24'h000040, pat(32'h33));
    tick();

    // Refresh: first refresh command in cycle 17 after release
    rrst_n_b = 1'b1;
    repeat (16) tick();
    chk("ref.c16_valid", 256'(cmd_valid_b), 256'(0));
    tick();
    chk("ref.c17_valid", 256'(cmd_valid_b), 256'(1));
    chk("ref.c17_wr",    256'(cmd_wr_b),    256'(0));
    chk("ref.c17_addr",  256'(cmd_addr_b),  256'(0));
    chk("ref.c17_data",  cmd_data_b,        256'(0));
    $display("txn ref.first: wr=%0b addr=%06h", cmd_wr_b, cmd_addr_b);
    // Now cycle 17; strobe in cycle 31 so write and refresh are both pending in cycle 32
    repeat (14) tick();
    pkt0_valid_b = 1'b1; pkt0_data_b = pat(32'h40);
    tick();
    pkt0_valid_b = 1'b0;
    tick();
    chk("ref.prio_valid", 256'(cmd_valid_b), 256'(1));
    chk("ref.prio_wr",    256'(cmd_wr_b),    256'(0));
    $display("txn ref.second: wr=%0b addr=%06h", cmd_wr_b, cmd_addr_b);
    tick();
    chk("ref.prio_gap", 256'(cmd_valid_b), 256'(0));
    tick();
    chk("ref.wr_valid", 256'(cmd_valid_b), 256'(1));
    chk("ref.wr_wr",    256'(cmd_wr_b),    256'(1));
    chk("ref.wr_addr",  256'(cmd_addr_b),  256'(24'h001000));
    chk("ref.wr_data",  cmd_data_b,        pat(32'h40));
    $display("txn ref.write: wr=%0b addr=%06h data[31:0]=%08h", cmd_wr_b, cmd_addr_b, cmd_data_b[31:0]);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
